// File: rtl/apix_pkg.sv
// Shared constants and the CRC-8 step function for the APIX receive path.
package apix_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam logic [7:0] CRC_POLY  = 8'h07;
    localparam logic [7:0] CRC_INIT  = 8'h00;

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] CRC  = 2'd2;

    // One byte of CRC-8, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data_byte);
        logic [7:0] c;
        c = crc ^ data_byte;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/apix_pix_fifo.sv
// Synchronous first-word fall-through FIFO; a push into a full FIFO only lands if a pop frees a slot.
module apix_pix_fifo #(
    parameter int DATA_W = 25,
    parameter int DEPTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_full,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    // Head is forced to zero when empty so the outputs are defined out of reset.
    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full     = w_full;
    assign o_empty    = w_empty;

endmodule

// File: rtl/apix_rx_deframer.sv
// APIX receive deframer: sync hunt, pixel assembly, trailing CRC-8 check and
// cut-through pixel delivery through an output FIFO.
module apix_rx_deframer
    import apix_pkg::*;
#(
    parameter int PIXEL_BYTES   = 3,
    parameter int PIX_PER_FRAME = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT       = 64,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic [8*PIXEL_BYTES-1:0] pix_data,
    output logic                     pix_valid,
    output logic                     pix_last,
    input  logic                     pix_ready,
    output logic                     frame_ok,
    output logic                     crc_err,
    output logic                     frame_abort,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int PW  = 8 * PIXEL_BYTES;
    localparam int BCW = (PIXEL_BYTES > 1) ? $clog2(PIXEL_BYTES) : 1;
    localparam int PCW = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
    localparam int TCW = $clog2(TIMEOUT);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(PIXEL_BYTES - 1);
    localparam logic [PCW-1:0] LAST_PIX  = PCW'(PIX_PER_FRAME - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);

    logic [1:0]           r_state,     w_state_nx;
    logic [BCW-1:0]       r_byte_cnt,  w_byte_cnt_nx;
    logic [PCW-1:0]       r_pix_cnt,   w_pix_cnt_nx;
    logic [7:0]           r_crc,       w_crc_nx;
    logic [PW-1:0]        r_asm,       w_asm_nx;
    logic [TCW-1:0]       r_to_cnt,    w_to_cnt_nx;
    logic [ERR_CNT_W-1:0] r_err_count, w_err_count_nx;
    logic                 r_frame_ok,  w_frame_ok_nx;
    logic                 r_crc_err,   w_crc_err_nx;
    logic                 r_abort,     w_abort_nx;
    logic                 r_ovf,       w_ovf_nx;

    logic [PW-1:0] w_pix;
    logic          w_push;
    logic [PW:0]   w_push_data;
    logic [PW:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    // Assembly register with the current byte already dropped into its lane.
    always_comb begin
        w_pix = r_asm;
        for (int i = 0; i < PIXEL_BYTES; i++) begin
            if (r_byte_cnt == BCW'(i)) w_pix[8*i +: 8] = in_data;
        end
    end

    assign w_push      = (r_state == DATA) && in_valid && (r_byte_cnt == LAST_BYTE);
    assign w_push_data = {(r_pix_cnt == LAST_PIX), w_pix};
    assign w_pop       = pix_ready && !w_empty;

    always_comb begin
        w_state_nx     = r_state;
        w_byte_cnt_nx  = r_byte_cnt;
        w_pix_cnt_nx   = r_pix_cnt;
        w_crc_nx       = r_crc;
        w_asm_nx       = r_asm;
        w_to_cnt_nx    = r_to_cnt;
        w_err_count_nx = r_err_count;
        w_frame_ok_nx  = 1'b0;
        w_crc_err_nx   = 1'b0;
        w_abort_nx     = 1'b0;

        case (r_state)
            HUNT: begin
                w_to_cnt_nx = '0;
                if (in_valid && (in_data == SYNC_BYTE)) begin
                    w_state_nx    = DATA;
                    w_byte_cnt_nx = '0;
                    w_pix_cnt_nx  = '0;
                    w_crc_nx      = CRC_INIT;
                end
            end
            DATA: begin
                if (in_valid) begin
                    w_to_cnt_nx = '0;
                    w_asm_nx    = w_pix;
                    w_crc_nx    = crc8_byte(r_crc, in_data);
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_byte_cnt_nx = '0;
                        if (r_pix_cnt == LAST_PIX) w_state_nx = CRC;
                        else w_pix_cnt_nx = r_pix_cnt + PCW'(1);
                    end else begin
                        w_byte_cnt_nx = r_byte_cnt + BCW'(1);
                    end
                end
            end
            CRC: begin
                if (in_valid) begin
                    w_to_cnt_nx = '0;
                    w_state_nx  = HUNT;
                    if (in_data == r_crc) begin
                        w_frame_ok_nx = 1'b1;
                    end else begin
                        w_crc_err_nx = 1'b1;
                        if (!(&r_err_count)) w_err_count_nx = r_err_count + ERR_CNT_W'(1);
                    end
                end
            end
            default: w_state_nx = HUNT;
        endcase

        // Idle timeout inside a frame; the partial pixel is lost, FIFO contents stay.
        if (((r_state == DATA) || (r_state == CRC)) && !in_valid) begin
            if (r_to_cnt == TO_LAST) begin
                w_abort_nx  = 1'b1;
                w_state_nx  = HUNT;
                w_to_cnt_nx = '0;
            end else begin
                w_to_cnt_nx = r_to_cnt + TCW'(1);
            end
        end
    end

    // Set wins over clear when a drop and ovf_clr coincide.
    always_comb begin
        w_ovf_nx = r_ovf;
        if (ovf_clr) w_ovf_nx = 1'b0;
        if (w_push && w_full && !w_pop) w_ovf_nx = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_byte_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_crc       <= CRC_INIT;
            r_asm       <= '0;
            r_to_cnt    <= '0;
            r_err_count <= '0;
            r_frame_ok  <= 1'b0;
            r_crc_err   <= 1'b0;
            r_abort     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_byte_cnt  <= w_byte_cnt_nx;
            r_pix_cnt   <= w_pix_cnt_nx;
            r_crc       <= w_crc_nx;
            r_asm       <= w_asm_nx;
            r_to_cnt    <= w_to_cnt_nx;
            r_err_count <= w_err_count_nx;
            r_frame_ok  <= w_frame_ok_nx;
            r_crc_err   <= w_crc_err_nx;
            r_abort     <= w_abort_nx;
            r_ovf       <= w_ovf_nx;
        end
    end

    apix_pix_fifo #(
        .DATA_W (PW + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .o_full      (w_full),
        .i_pop       (pix_ready),
        .o_pop_data  (w_head),
        .o_empty     (w_empty)
    );

    assign pix_data    = w_head[PW-1:0];
    assign pix_last    = w_head[PW];
    assign pix_valid   = !w_empty;
    assign frame_ok    = r_frame_ok;
    assign crc_err     = r_crc_err;
    assign frame_abort = r_abort;
    assign ovf         = r_ovf;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_apix_rx_deframer.sv
// Scoreboard bench for apix_rx_deframer: frames are modelled whole, expected pixels and
// frame events are queued at issue time and a monitor checks them as the DUT presents them.
module tb_apix_rx_deframer;

    localparam int PB    = 3;
    localparam int PPF   = 4;
    localparam int DEPTH = 8;
    localparam int TO    = 64;
    localparam int EW    = 8;
    localparam int PW    = 8 * PB;
    localparam int NB    = PB * PPF;

    localparam logic [2:0] EV_OK  = 3'b100;
    localparam logic [2:0] EV_ERR = 3'b010;
    localparam logic [2:0] EV_ABT = 3'b001;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic [PW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_last;
    logic          pix_ready;
    logic          frame_ok;
    logic          crc_err;
    logic          frame_abort;
    logic          ovf;
    logic          ovf_clr;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    apix_rx_deframer #(
        .PIXEL_BYTES   (PB),
        .PIX_PER_FRAME (PPF),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT       (TO),
        .ERR_CNT_W     (EW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .frame_ok    (frame_ok),
        .crc_err     (crc_err),
        .frame_abort (frame_abort),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .err_count   (err_count)
    );

    typedef struct packed {
        logic [PW-1:0] d;
        logic          l;
    } pix_t;

    typedef struct packed {
        logic [2:0]    ev;
        logic [EW-1:0] ec;
    } ev_t;

    pix_t       exp_pix[$];
    ev_t        exp_ev[$];
    pix_t       mon_p;
    ev_t        mon_e;
    int         n_chk = 0;
    int         n_err = 0;
    int         exp_errc = 0;
    int         keep_left = -1;
    bit         ready_en = 1'b0;
    logic [7:0] fb [NB];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference CRC: bitwise long division of the whole payload, MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] m [NB]);
        logic [7:0] r;
        logic       f;
        r = 8'h00;
        for (int i = 0; i < NB; i++) begin
            for (int b = 7; b >= 0; b--) begin
                f = r[7] ^ m[i][b];
                r = {r[6:0], 1'b0};
                if (f) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    function automatic int rg();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_pix(input int p);
        pix_t e;
        for (int k = 0; k < PB; k++) e.d[8*k +: 8] = fb[PB*p + k];
        e.l = (p == PPF - 1);
        if (keep_left != 0) begin
            exp_pix.push_back(e);
            if (keep_left > 0) keep_left--;
        end
    endtask

    task automatic push_ev(input logic [2:0] code);
        ev_t e;
        if (code == EV_ERR) exp_errc = (exp_errc == (1 << EW) - 1) ? exp_errc : exp_errc + 1;
        e.ev = code;
        e.ec = EW'(exp_errc);
        exp_ev.push_back(e);
    endtask

    task automatic send_frame(input bit bad, input int gap_at, input int gap_len, input bit rnd);
        logic [7:0] c;
        c = ref_crc(fb);
        for (int p = 0; p < PPF; p++) push_pix(p);
        push_ev(bad ? EV_ERR : EV_OK);
        drive_byte(8'hFF, 0);
        for (int i = 0; i < NB; i++) drive_byte(fb[i], (i == gap_at) ? gap_len : (rnd ? rg() : 0));
        drive_byte(bad ? ~c : c, rnd ? rg() : 0);
    endtask

    task automatic fill_seq();
        for (int i = 0; i < NB; i++) fb[i] = 8'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NB; i++)
            fb[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_pix.size() != 0 || exp_ev.size() != 0 || pix_valid) && t < 4000) begin
            tick();
            t++;
        end
        chk({name, "_pix_left"}, 64'(exp_pix.size()), 64'd0);
        chk({name, "_ev_left"}, 64'(exp_ev.size()), 64'd0);
    endtask

    // Monitor: checks every handshake and every frame event against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pix_valid && pix_ready) begin
                    if (exp_pix.size() == 0) begin
                        chk("pix_unexpected", 64'(pix_data), 64'hDEAD_0000_0000);
                    end else begin
                        mon_p = exp_pix.pop_front();
                        chk("pix_data", 64'(pix_data), 64'(mon_p.d));
                        chk("pix_last", 64'(pix_last), 64'(mon_p.l));
                    end
                end
                if (frame_ok || crc_err || frame_abort) begin
                    if (exp_ev.size() == 0) begin
                        chk("ev_unexpected", 64'({frame_ok, crc_err, frame_abort}), 64'd0);
                    end else begin
                        mon_e = exp_ev.pop_front();
                        chk("ev_kind", 64'({frame_ok, crc_err, frame_abort}), 64'(mon_e.ev));
                        chk("ev_err_count", 64'(err_count), 64'(mon_e.ec));
                    end
                end
            end
        end
    end

    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = ready_en && ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_pix_valid"}, 64'(pix_valid), 64'd0);
        chk({name, "_pix_data"}, 64'(pix_data), 64'd0);
        chk({name, "_pix_last"}, 64'(pix_last), 64'd0);
        chk({name, "_pulses"}, 64'({frame_ok, crc_err, frame_abort}), 64'd0);
        chk({name, "_ovf"}, 64'(ovf), 64'd0);
        chk({name, "_err_count"}, 64'(err_count), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ovf_clr  = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        ready_en = 1'b1;

        // Known frame, then the same frame with the CRC byte inverted.
        fill_seq();
        send_frame(1'b0, -1, 0, 1'b0);
        drain("good");
        send_frame(1'b1, -1, 0, 1'b0);
        drain("bad");
        chk("err_count_1", 64'(err_count), 64'd1);

        // Idle gaps inside a frame, including one cycle short of the timeout.
        send_frame(1'b0, 5, 10, 1'b0);
        send_frame(1'b0, 5, TO - 1, 1'b0);
        drain("gaps");

        // Timeout after byte 5: one pixel survives, partial pixel is lost.
        push_pix(0);
        push_ev(EV_ABT);
        drive_byte(8'hFF, 0);
        for (int i = 0; i < 5; i++) drive_byte(fb[i], 0);
        repeat (TO + 2) tick();
        drain("abort");
        send_frame(1'b0, -1, 0, 1'b0);
        drain("after_abort");

        // Leading garbage is ignored; sync value inside data is payload.
        drive_byte(8'h00, 0);
        drive_byte(8'h12, 1);
        drive_byte(8'hFE, 0);
        fb[4] = 8'hFF;
        fb[7] = 8'hFF;
        send_frame(1'b0, -1, 0, 1'b0);
        drain("garbage");

        // Overflow with a stalled sink: only the first DEPTH pixels are kept.
        ready_en = 1'b0;
        repeat (2) tick();
        keep_left = DEPTH;
        for (int f = 0; f < 3; f++) begin
            fill_rand();
            send_frame(1'b0, -1, 0, 1'b0);
        end
        keep_left = -1;
        repeat (2) tick();
        chk("ovf_set", 64'(ovf), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 64'(pix_valid), 64'd1);
            chk("stall_head", 64'(pix_data), 64'(exp_pix[0].d));
            tick();
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);
        ready_en = 1'b1;
        drain("ovf");

        // Reset in the middle of a frame discards everything.
        ready_en = 1'b0;
        repeat (2) tick();
        fill_seq();
        drive_byte(8'hFF, 0);
        for (int i = 0; i < 7; i++) drive_byte(fb[i], 0);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        exp_errc = 0;
        tick();
        rst = 1'b0;
        tick();
        ready_en = 1'b1;
        send_frame(1'b0, -1, 0, 1'b0);
        drain("post_reset");

        // Randomised frames with garbage, gaps and random CRC corruption.
        for (int f = 0; f < 40; f++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++)
                drive_byte(8'($urandom_range(0, 254)), int'($urandom_range(0, 2)));
            fill_rand();
            send_frame(1'($urandom_range(0, 1)), -1, 0, 1'b1);
        end
        drain("random");

        // Saturation of the error counter.
        for (int f = 0; f < 256; f++) begin
            fill_rand();
            send_frame(1'b1, -1, 0, 1'b0);
        end
        drain("saturate");
        chk("err_count_sat", 64'(err_count), 64'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
